// File: rtl/uc_sequencer.sv
// -----------------------------------------------------------------------------
// uc_sequencer
// Control unit for the single-cycle microcontroller datapath. Decodes the
// 6-bit opcode and the registered zero flag into the datapath control word.
// Execution runs under a run/stop/single-step/halt state machine. A saturating
// counter tracks retired instructions.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   opcode  in   instruc[15:10] from the datapath
//   z_flag  in   registered zero flag from the datapath
//   start   in   begin or resume free-running execution
//   stop    in   return to IDLE after the current instruction
//   step    in   execute exactly one instruction from IDLE
//   s_inc   out  PC mux select (1 = PC+1, 0 = jump target)
//   s_inm   out  regfile write-data select (1 = immediate, 0 = ALU)
//   we3     out  regfile write enable
//   wez     out  zero-flag load enable
//   Op      out  ALU operation select
//   pc_en   out  PC register load enable
//   halted  out  high while in HALTED (registered)
//   illegal out  sticky flag, set when an undefined opcode executes
//   icount  out  retired-instruction count, saturating
// -----------------------------------------------------------------------------
module uc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z_flag,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    HALTED = 3'd3,
    RESUME = 3'd4
  } state_t;

  state_t state;

  logic exec_s;
  logic is_halt_s;
  logic is_illegal_s;

  assign exec_s    = (state == RUN) || (state == STEP);
  assign is_halt_s = (opcode == 6'b000111);
  // Opcodes 000100..001111, except HALT, have no defined meaning.
  assign is_illegal_s = (opcode[5:4] == 2'b00) && (opcode[3:0] > 4'd3) && !is_halt_s;

  // Control word decode from state, opcode and zero flag.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_en = 1'b0;
    if (state == RESUME) begin
      // Step past the HALT word without touching any register.
      pc_en = 1'b1;
    end else if (exec_s) begin
      if (opcode[5]) begin
        Op    = opcode[4:2];
        we3   = 1'b1;
        wez   = 1'b1;
        pc_en = 1'b1;
      end else if (opcode[4]) begin
        s_inm = 1'b1;
        we3   = 1'b1;
        pc_en = 1'b1;
      end else begin
        case (opcode[3:0])
          4'd1:    begin s_inc = 1'b0;    pc_en = 1'b1; end
          4'd2:    begin s_inc = ~z_flag; pc_en = 1'b1; end
          4'd3:    begin s_inc = z_flag;  pc_en = 1'b1; end
          4'd7:    begin pc_en = 1'b0; end
          default: begin pc_en = 1'b1; end
        endcase
      end
    end else begin
      pc_en = 1'b0;
    end
  end

  // Sequencer state, halted flag, sticky illegal flag and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      halted  <= 1'b0;
      illegal <= 1'b0;
      icount  <= '0;
    end else begin
      if (exec_s && !is_halt_s && (icount != {CNT_W{1'b1}})) begin
        icount <= icount + CNT_W'(1);
      end
      if (exec_s && is_illegal_s) begin
        illegal <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
          end else if (step) begin
            state <= STEP;
          end
          halted <= 1'b0;
        end
        RUN: begin
          // HALT wins over stop; a stopped instruction still executes.
          if (is_halt_s) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (stop) begin
            state  <= IDLE;
            halted <= 1'b0;
          end else begin
            halted <= 1'b0;
          end
        end
        STEP: begin
          if (is_halt_s) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        HALTED: begin
          if (start) begin
            state  <= RESUME;
            halted <= 1'b0;
          end else begin
            halted <= 1'b1;
          end
        end
        RESUME: begin
          state  <= stop ? IDLE : RUN;
          halted <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for uc_sequencer. A behavioural model of the sequencer's rules
// predicts every output each cycle. A second instance with a 4-bit counter
// lets the saturation rule be reached in a few cycles.
// -----------------------------------------------------------------------------
module tb_uc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       z_flag = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;

  logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]  Op;
  logic [15:0] icount;
  logic        n_s_inc, n_s_inm, n_we3, n_wez, n_pc_en, n_halted, n_illegal;
  logic [2:0]  n_Op;
  logic [3:0]  n_icount;

  always #5 clk = ~clk;

  uc_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z_flag(z_flag),
    .start(start), .stop(stop), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .illegal(illegal), .icount(icount)
  );

  uc_sequencer #(.CNT_W(4)) dut_narrow (
    .clk(clk), .reset(reset), .opcode(opcode), .z_flag(z_flag),
    .start(start), .stop(stop), .step(step),
    .s_inc(n_s_inc), .s_inm(n_s_inm), .we3(n_we3), .wez(n_wez), .Op(n_Op),
    .pc_en(n_pc_en), .halted(n_halted), .illegal(n_illegal), .icount(n_icount)
  );

  // Observed: {cw(10), icount(16), narrow cw(10), narrow icount(4)}
  logic [39:0] obs;
  assign obs = {s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal, icount,
                n_s_inc, n_s_inm, n_we3, n_wez, n_Op, n_pc_en, n_halted, n_illegal, n_icount};

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3, M_RESUME = 4;
  int          m_mode = M_IDLE;
  int          m_count = 0;
  int          m_count_n = 0;
  bit          m_illegal = 1'b0;
  logic [39:0] exp_vec;

  localparam logic [5:0] OP_NOP = 6'b000000, OP_J = 6'b000001, OP_JZ = 6'b000010,
                         OP_JNZ = 6'b000011, OP_HALT = 6'b000111, OP_BAD = 6'b000100;

  function automatic bit is_undefined(input int o);
    return (o < 16) && (o > 3) && (o != 7);
  endfunction

  task automatic model_expect();
    int o;
    logic e_sinc, e_sinm, e_we3, e_wez, e_pcen;
    logic [2:0] e_op;
    logic [9:0] cw;
    o = int'(opcode);
    e_sinc = 1'b1; e_sinm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0; e_op = 3'd0; e_pcen = 1'b0;
    if (m_mode == M_RESUME) begin
      e_pcen = 1'b1;
    end else if ((m_mode == M_RUN) || (m_mode == M_STEP)) begin
      if (o != 7) begin
        e_pcen = 1'b1;
        if (o >= 32) begin
          e_op = 3'((o / 4) % 8); e_we3 = 1'b1; e_wez = 1'b1;
        end else if (o >= 16) begin
          e_sinm = 1'b1; e_we3 = 1'b1;
        end else if (o == 1) begin
          e_sinc = 1'b0;
        end else if (o == 2) begin
          e_sinc = !z_flag;
        end else if (o == 3) begin
          e_sinc = z_flag;
        end
      end
    end
    cw = {e_sinc, e_sinm, e_we3, e_wez, e_op, e_pcen, (m_mode == M_HALTED), m_illegal};
    exp_vec = {cw, 16'(m_count), cw, 4'(m_count_n)};
  endtask

  task automatic model_next();
    int o;
    o = int'(opcode);
    if (reset) begin
      m_mode = M_IDLE; m_count = 0; m_count_n = 0; m_illegal = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE:   if (start) m_mode = M_RUN; else if (step) m_mode = M_STEP;
        M_RUN, M_STEP: begin
          if (o != 7) begin
            if (m_count < 65535) m_count = m_count + 1;
            if (m_count_n < 15) m_count_n = m_count_n + 1;
          end
          if (is_undefined(o)) m_illegal = 1'b1;
          if (o == 7) m_mode = M_HALTED;
          else if (m_mode == M_STEP) m_mode = M_IDLE;
          else if (stop) m_mode = M_IDLE;
        end
        M_HALTED: if (start) m_mode = M_RESUME;
        M_RESUME: m_mode = stop ? M_IDLE : M_RUN;
        default:  m_mode = M_IDLE;
      endcase
    end
  endtask

  // Apply one cycle of inputs and compute the expected outputs for it.
  task automatic drive(input logic [5:0] op, input logic z, input logic st,
                       input logic sp, input logic stp, input logic rst);
    @(negedge clk);
    opcode = op; z_flag = z; start = st; stop = sp; step = stp; reset = rst;
    #1;
    model_expect();
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(OP_NOP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, i == 0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_program();
    logic [5:0] prog [5] = '{6'b010101, 6'b010011, 6'b101000, OP_HALT, OP_HALT};
    drive(prog[0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp_vec) begin
      miscompares++;
      $display("FAIL program_start: got %h want %h", obs, exp_vec);
    end
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(prog[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL program[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_jumps();
    // From HALTED: start (RESUME), then jumps in RUN, then stop.
    logic [5:0] ops [7] = '{OP_NOP, OP_NOP, OP_JZ, OP_JZ, OP_JNZ, OP_J, OP_JNZ};
    logic       zs  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       sts [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       sps [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], zs[i], sts[i], sps[i], 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL jumps[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_step();
    // step, idle, step, idle, then start+step together, run, stop.
    logic sts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic sps [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic stp [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 7; i++) begin
      drive(6'b100100, 1'b0, sts[i], sps[i], stp[i], 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL step[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
    drive(6'b100100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp_vec) begin
      miscompares++;
      $display("FAIL step_idle: got %h want %h", obs, exp_vec);
    end
    advance();
  endtask

  task automatic test_stop();
    // start, ALU with stop, idle, start, ALU, HALT with stop, halted.
    logic [5:0] ops [7] = '{6'b111100, 6'b110000, 6'b111100, 6'b111100, 6'b100000, OP_HALT, OP_NOP};
    logic       sts [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       sps [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], 1'b0, sts[i], sps[i], i == 6, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL stop[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_resume_illegal();
    // HALTED: start -> RESUME -> RUN; illegal opcode; HALT; RESUME with stop;
    // then start, run, reset mid-run.
    logic [5:0] ops [12] = '{OP_HALT, OP_HALT, OP_BAD, OP_NOP, OP_HALT, OP_HALT, OP_NOP,
                             OP_NOP, 6'b101100, 6'b101100, 6'b011111, OP_NOP};
    logic       sts [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       sps [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rst [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], 1'b0, sts[i], sps[i], 1'b0, rst[i]);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL resume_illegal[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(6'b110100, 1'b0, i == 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: op = {1'b1, 5'($urandom)};
        3:       op = {2'b01, 4'($urandom)};
        4:       op = OP_HALT;
        5:       op = OP_JZ;
        6:       op = OP_JNZ;
        7:       op = OP_J;
        8:       op = {2'b00, 4'($urandom)};
        default: op = OP_NOP;
      endcase
      drive(op, 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_jumps();
    test_step();
    test_stop();
    test_resume_illegal();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
